// File: rtl/mat_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mat_mem_arbiter
// Round-robin arbiter sharing the matrix memory between the compute sequencer
// and the host loader, with locked bursts and tagged fixed-latency read return.
// Rev    : 1.0
// ============================================================================
module mat_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,          // synchronous, active-low
  input  logic                  c_req_i,
  input  logic                  h_req_i,
  input  logic                  c_write_i,
  input  logic                  h_write_i,
  input  logic                  c_lock_i,
  input  logic                  h_lock_i,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  input  logic [ADDR_WIDTH-1:0] h_addr_i,
  input  logic [DATA_WIDTH-1:0] c_wdata_i,
  input  logic [DATA_WIDTH-1:0] h_wdata_i,
  output logic                  c_gnt_o,
  output logic                  h_gnt_o,
  output logic                  c_rvalid_o,
  output logic                  h_rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_writedata_o,
  input  logic [DATA_WIDTH-1:0] mem_readdata_i,
  output logic [1:0]            owner_o
);

  localparam int                   CNT_WIDTH = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic                 SEL_C     = 1'b0;
  localparam logic                 SEL_H     = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_C    = 2'b01,
    OWN_H    = 2'b10
  } owner_e;

  owner_e               owner_q, owner_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic c_gnt, h_gnt, gnt_any;
  logic sel_lock, sel_is_owner, other_req, forced;

  // Arbitration: a live owner keeps the port, otherwise round-robin on ties.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (reset_i) begin
      if (owner_q == OWN_C && c_req_i) begin
        c_gnt = 1'b1;
      end else if (owner_q == OWN_H && h_req_i) begin
        h_gnt = 1'b1;
      end else if (c_req_i && h_req_i) begin
        c_gnt = (last_q == SEL_H);
        h_gnt = (last_q == SEL_C);
      end else begin
        c_gnt = c_req_i;
        h_gnt = h_req_i;
      end
    end
  end

  assign gnt_any      = c_gnt | h_gnt;
  assign sel_lock     = h_gnt ? h_lock_i : c_lock_i;
  assign other_req    = h_gnt ? c_req_i : h_req_i;
  assign sel_is_owner = h_gnt ? (owner_q == OWN_H) : (owner_q == OWN_C);
  assign forced       = (cnt_q == CNT_LIMIT) && other_req;

  always_comb begin
    owner_d = OWN_NONE;
    cnt_d   = '0;
    last_d  = last_q;
    if (gnt_any) begin
      last_d = h_gnt ? SEL_H : SEL_C;
      if (sel_lock && !forced) begin
        owner_d = h_gnt ? OWN_H : OWN_C;
        if (!sel_is_owner) begin
          cnt_d = CNT_WIDTH'(1);
        end else if (cnt_q == CNT_LIMIT) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      owner_q <= OWN_NONE;
      last_q  <= SEL_H;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign c_gnt_o         = c_gnt;
  assign h_gnt_o         = h_gnt;
  assign owner_o         = owner_q;
  assign mem_read_o      = (c_gnt & ~c_write_i) | (h_gnt & ~h_write_i);
  assign mem_write_o     = (c_gnt &  c_write_i) | (h_gnt &  h_write_i);
  assign mem_addr_o      = c_gnt ? c_addr_i  : (h_gnt ? h_addr_i  : '0);
  assign mem_writedata_o = c_gnt ? c_wdata_i : (h_gnt ? h_wdata_i : '0);

  // Tag pipeline: bit 0 is the newest stage, the top bit lines up with mem_readdata.
  logic [RD_LATENCY-1:0] vld_q, tag_q;
  logic [RD_LATENCY:0]   vld_shift, tag_shift;

  assign vld_shift = {vld_q, mem_read_o};
  assign tag_shift = {tag_q, h_gnt};

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_shift[RD_LATENCY-1:0];
      tag_q <= tag_shift[RD_LATENCY-1:0];
    end
  end

  assign c_rvalid_o = vld_q[RD_LATENCY-1] & ~tag_q[RD_LATENCY-1];
  assign h_rvalid_o = vld_q[RD_LATENCY-1] &  tag_q[RD_LATENCY-1];
  assign rdata_o    = mem_readdata_i;

endmodule
`default_nettype wire

// File: tb/tb_mat_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mat_mem_arbiter
// Checks two arbiter instances (read latency 1 and 3) against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_mat_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          c_req, h_req, c_write, h_write, c_lock, h_lock;
  logic [AW-1:0] c_addr, h_addr;
  logic [DW-1:0] c_wdata, h_wdata;

  logic          u1_cg, u1_hg, u1_crv, u1_hrv, u1_mrd, u1_mwr;
  logic [DW-1:0] u1_rdata, u1_mwd, u1_mrdata;
  logic [AW-1:0] u1_maddr;
  logic [1:0]    u1_own;
  logic          u3_cg, u3_hg, u3_crv, u3_hrv, u3_mrd, u3_mwr;
  logic [DW-1:0] u3_rdata, u3_mwd, u3_mrdata;
  logic [AW-1:0] u3_maddr;
  logic [1:0]    u3_own;

  mat_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .MAX_BURST(MAXB)) u1 (
    .clock_i(clk), .reset_i(rst_n),
    .c_req_i(c_req), .h_req_i(h_req), .c_write_i(c_write), .h_write_i(h_write),
    .c_lock_i(c_lock), .h_lock_i(h_lock), .c_addr_i(c_addr), .h_addr_i(h_addr),
    .c_wdata_i(c_wdata), .h_wdata_i(h_wdata),
    .c_gnt_o(u1_cg), .h_gnt_o(u1_hg), .c_rvalid_o(u1_crv), .h_rvalid_o(u1_hrv),
    .rdata_o(u1_rdata), .mem_read_o(u1_mrd), .mem_write_o(u1_mwr),
    .mem_addr_o(u1_maddr), .mem_writedata_o(u1_mwd), .mem_readdata_i(u1_mrdata),
    .owner_o(u1_own)
  );

  mat_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .MAX_BURST(MAXB)) u3 (
    .clock_i(clk), .reset_i(rst_n),
    .c_req_i(c_req), .h_req_i(h_req), .c_write_i(c_write), .h_write_i(h_write),
    .c_lock_i(c_lock), .h_lock_i(h_lock), .c_addr_i(c_addr), .h_addr_i(h_addr),
    .c_wdata_i(c_wdata), .h_wdata_i(h_wdata),
    .c_gnt_o(u3_cg), .h_gnt_o(u3_hg), .c_rvalid_o(u3_crv), .h_rvalid_o(u3_hrv),
    .rdata_o(u3_rdata), .mem_read_o(u3_mrd), .mem_write_o(u3_mwr),
    .mem_addr_o(u3_maddr), .mem_writedata_o(u3_mwd), .mem_readdata_i(u3_mrdata),
    .owner_o(u3_own)
  );

  // Memories behind each instance, preloaded with 0xC0DE0000 + address.
  logic [DW-1:0] bmem1 [256];
  logic [DW-1:0] bmem3 [256];
  logic [DW-1:0] rd1;
  logic [DW-1:0] rp3 [3];
  logic          minit = 1'b0;

  always @(posedge clk) begin
    if (!minit) begin
      for (int i = 0; i < 256; i++) begin
        bmem1[i] <= 32'hC0DE_0000 + 32'(i);
        bmem3[i] <= 32'hC0DE_0000 + 32'(i);
      end
      minit <= 1'b1;
    end else begin
      if (u1_mwr) bmem1[u1_maddr] <= u1_mwd;
      if (u3_mwr) bmem3[u3_maddr] <= u3_mwd;
    end
    rd1    <= bmem1[u1_maddr];
    rp3[0] <= bmem3[u3_maddr];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign u1_mrdata = rd1;
  assign u3_mrdata = rp3[2];

  // Literal expectations from the directed sequence (-1 = not checked).
  int     l_cg, l_hg, l_own, l_crv1, l_hrv1, l_crv3;
  longint l_rd1, l_rd3;
  bit     run = 1'b0;

  int vectors  = 0;
  int errors   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner 0 none / 1 compute / 2 host; pending reads as a queue.
  typedef struct {
    int          due;
    int          who;
    logic [31:0] data;
  } resp_t;

  resp_t       q1[$];
  resp_t       q3[$];
  logic [31:0] refmem [256];
  bit          rinit = 1'b0;
  int          m_own = 0, m_last = 2, m_cnt = 0, cyc = 0;

  always @(negedge clk) begin
    int          eg, lk, oth;
    bit          e_wr, e_rd, v1, v3;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    resp_t       r;
    if (!rinit) begin
      for (int i = 0; i < 256; i++) refmem[i] = 32'hC0DE_0000 + 32'(i);
      rinit = 1'b1;
    end
    if (run) begin
      eg = 0;
      if (rst_n) begin
        if (m_own == 1 && c_req)      eg = 1;
        else if (m_own == 2 && h_req) eg = 2;
        else if (c_req && h_req)      eg = (m_last == 2) ? 1 : 2;
        else if (c_req)               eg = 1;
        else if (h_req)               eg = 2;
      end
      e_wr   = (eg == 1) ? c_write : (eg == 2) ? h_write : 1'b0;
      e_rd   = (eg != 0) && !e_wr;
      e_addr = (eg == 1) ? c_addr  : (eg == 2) ? h_addr  : 8'h00;
      e_wd   = (eg == 1) ? c_wdata : (eg == 2) ? h_wdata : 32'h0;
      v1 = (q1.size() > 0) && (q1[0].due == cyc);
      v3 = (q3.size() > 0) && (q3[0].due == cyc);

      chk("u1_c_gnt", 64'(u1_cg), 64'(eg == 1));
      chk("u1_h_gnt", 64'(u1_hg), 64'(eg == 2));
      chk("u3_c_gnt", 64'(u3_cg), 64'(eg == 1));
      chk("u3_h_gnt", 64'(u3_hg), 64'(eg == 2));
      chk("u1_mem_read",  64'(u1_mrd), 64'(e_rd));
      chk("u1_mem_write", 64'(u1_mwr), 64'(e_wr));
      chk("u3_mem_read",  64'(u3_mrd), 64'(e_rd));
      chk("u3_mem_write", 64'(u3_mwr), 64'(e_wr));
      chk("u1_mem_addr",  64'(u1_maddr), 64'(e_addr));
      chk("u1_mem_wdata", 64'(u1_mwd),   64'(e_wd));
      chk("u3_mem_addr",  64'(u3_maddr), 64'(e_addr));
      chk("u1_owner", 64'(u1_own), 64'(m_own));
      chk("u3_owner", 64'(u3_own), 64'(m_own));
      chk("u1_c_rvalid", 64'(u1_crv), 64'(v1 && q1[0].who == 1));
      chk("u1_h_rvalid", 64'(u1_hrv), 64'(v1 && q1[0].who == 2));
      chk("u3_c_rvalid", 64'(u3_crv), 64'(v3 && q3[0].who == 1));
      chk("u3_h_rvalid", 64'(u3_hrv), 64'(v3 && q3[0].who == 2));
      if (v1) chk("u1_rdata", 64'(u1_rdata), 64'(q1[0].data));
      if (v3) chk("u3_rdata", 64'(u3_rdata), 64'(q3[0].data));

      if (l_cg   >= 0) chk("lit_c_gnt",    64'(u1_cg),    64'(l_cg));
      if (l_hg   >= 0) chk("lit_h_gnt",    64'(u1_hg),    64'(l_hg));
      if (l_own  >= 0) chk("lit_owner",    64'(u3_own),   64'(l_own));
      if (l_crv1 >= 0) chk("lit_u1_crv",   64'(u1_crv),   64'(l_crv1));
      if (l_hrv1 >= 0) chk("lit_u1_hrv",   64'(u1_hrv),   64'(l_hrv1));
      if (l_crv3 >= 0) chk("lit_u3_crv",   64'(u3_crv),   64'(l_crv3));
      if (l_rd1  >= 0) chk("lit_u1_rdata", 64'(u1_rdata), 64'(l_rd1));
      if (l_rd3  >= 0) chk("lit_u3_rdata", 64'(u3_rdata), 64'(l_rd3));

      if (v1) void'(q1.pop_front());
      if (v3) void'(q3.pop_front());
      if (!rst_n) begin
        m_own = 0; m_last = 2; m_cnt = 0;
        q1.delete(); q3.delete();
      end else if (eg != 0) begin
        if (e_wr) begin
          refmem[e_addr] = e_wd;
        end else begin
          r.who = eg; r.data = refmem[e_addr];
          r.due = cyc + 1; q1.push_back(r);
          r.due = cyc + 3; q3.push_back(r);
        end
        lk  = (eg == 1) ? int'(c_lock) : int'(h_lock);
        oth = (eg == 1) ? int'(h_req)  : int'(c_req);
        if (lk != 0 && !(m_cnt == MAXB - 1 && oth != 0)) begin
          m_cnt = (m_own == eg) ? ((m_cnt + 1 > MAXB - 1) ? MAXB - 1 : m_cnt + 1) : 1;
          m_own = eg;
        end else begin
          m_own = 0; m_cnt = 0;
        end
        m_last = eg;
      end else begin
        m_own = 0; m_cnt = 0;
      end
      cyc++;
    end
  end

  task automatic clr_lit();
    l_cg = -1; l_hg = -1; l_own = -1; l_crv1 = -1; l_hrv1 = -1; l_crv3 = -1;
    l_rd1 = -1; l_rd3 = -1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    clr_lit();
  endtask

  task automatic set_c(input bit r, input bit w, input bit lk, input logic [7:0] a, input logic [31:0] d);
    c_req = r; c_write = w; c_lock = lk; c_addr = a; c_wdata = d;
  endtask

  task automatic set_h(input bit r, input bit w, input bit lk, input logic [7:0] a, input logic [31:0] d);
    h_req = r; h_write = w; h_lock = lk; h_addr = a; h_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    set_c(1, 0, 0, 8'h10, 0);
    set_h(1, 0, 0, 8'h20, 0);
    clr_lit();
    @(posedge clk);
    #1;
    run = 1'b1;

    // reset held with both requesting
    for (int k = 0; k < 3; k++) begin
      l_cg = 0; l_hg = 0; l_own = 0;
      next();
    end
    rst_n = 1'b1;

    // round-robin unlocked reads
    for (int k = 0; k < 6; k++) begin
      l_cg = (k % 2 == 0) ? 1 : 0;
      l_hg = (k % 2 == 1) ? 1 : 0;
      l_own = 0;
      if (k > 0) begin
        l_crv1 = ((k - 1) % 2 == 0) ? 1 : 0;
        l_hrv1 = ((k - 1) % 2 == 1) ? 1 : 0;
        l_rd1  = (l_crv1 == 1) ? 64'hC0DE_0010 : 64'hC0DE_0020;
      end
      next();
    end
    set_c(0, 0, 0, 0, 0);
    set_h(0, 0, 0, 0, 0);
    repeat (4) next();

    // locked compute burst, host waits until lock drops
    for (int k = 0; k < 6; k++) begin
      set_c(k < 5, 0, k < 4, 8'(8'h40 + k), 0);
      set_h(k >= 2, 0, 0, 8'h30, 0);
      l_cg  = (k < 5) ? 1 : 0;
      l_hg  = (k == 5) ? 1 : 0;
      l_own = (k >= 1 && k <= 4) ? 1 : 0;
      if (k >= 1) begin
        l_crv1 = 1;
        l_rd1  = 64'hC0DE_0040 + 64'(k - 1);
      end
      next();
    end
    set_h(0, 0, 0, 0, 0);
    l_hrv1 = 1; l_crv1 = 0; l_rd1 = 64'hC0DE_0030;
    next();
    repeat (3) next();

    // starvation limit
    for (int k = 0; k < 9; k++) begin
      set_c(1, 0, 1, 8'h50, 0);
      set_h(1, 0, 0, 8'h60, 0);
      l_cg  = (k < 8) ? 1 : 0;
      l_hg  = (k == 8) ? 1 : 0;
      l_own = (k >= 1 && k <= 7) ? 1 : 0;
      next();
    end
    set_c(0, 0, 0, 0, 0);
    set_h(0, 0, 0, 0, 0);
    repeat (4) next();

    // host write then compute read of the same word
    set_h(1, 1, 0, 8'h05, 32'hDEAD_BEEF);
    l_hg = 1; l_cg = 0; l_hrv1 = 0;
    next();
    set_h(0, 0, 0, 0, 0);
    set_c(1, 0, 0, 8'h05, 0);
    l_cg = 1; l_hrv1 = 0;
    next();
    set_c(0, 0, 0, 0, 0);
    l_crv1 = 1; l_hrv1 = 0; l_rd1 = 64'hDEAD_BEEF;
    next();
    l_hrv1 = 0;
    next();
    l_crv3 = 1; l_rd3 = 64'hDEAD_BEEF; l_hrv1 = 0;
    next();

    // reset with reads in flight
    set_c(1, 0, 0, 8'h10, 0);
    l_cg = 1;
    next();
    l_cg = 1;
    next();
    rst_n = 1'b0;
    set_c(0, 0, 0, 0, 0);
    l_cg = 0; l_crv3 = 0;
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      l_crv3 = 0; l_crv1 = 0;
      if (k == 0) l_own = 0;
      next();
    end

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      set_c($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 15)), $urandom);
      set_h($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 15)), $urandom);
      next();
    end

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
